iram_loader: RTL and testbench

- Byte-stream program loader sitting directly upstream of the 8x256 instruction RAM; drives its write port (`ram_wadr`, `ram_wdata`, `ram_wen`).
- Parses framed bytes from the UART receiver and writes the payload into instruction RAM.
- Verifies a checksum at the end of each frame.
- Holds the CPU stopped while loading; releases it with a start PC once a frame verifies good.

---
 rtl/iram_loader.sv | 244 ++++++++++++++++++++++++
 tb/tb_iram_loader.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/iram_loader.sv
// -----------------------------------------------------------------------------
// iram_loader
//
// Byte-stream program loader for the 8x256 instruction RAM. Framed bytes from
// the UART receiver are parsed, the payload is written through the RAM write
// port, and a trailing checksum decides whether the CPU is released.
//
// Frame: SYNC_BYTE, ADR, LEN, LEN+1 data bytes, SUM
//        LEN = byte count - 1 (0..255 -> 1..256 bytes)
//        good frame: (ADR + LEN + data... + SUM) mod 256 == 0
//
// Optional feature macro: LOADER_TIMEOUT_EN
//   When defined, an inter-byte timer aborts a stalled frame after
//   TIMEOUT_CYCLES clocks (load_err pulses, FSM returns to IDLE). When
//   undefined, the timer and its parameter do not exist and the loader waits
//   forever for the next byte.
//
// Ports:
//   clk        in   1  system clock, rising edge
//   rst_n      in   1  asynchronous active-low reset
//   rx_data    in   8  received byte from UART RX
//   rx_valid   in   1  one-cycle strobe, rx_data valid this cycle
//   ram_wadr   out  8  instruction RAM write address
//   ram_wdata  out  8  instruction RAM write data
//   ram_wen    out  1  instruction RAM write enable (one-cycle pulse)
//   cpu_run    out  1  1 = CPU may run, 0 = CPU held
//   start_pc   out  8  PC the CPU starts from when cpu_run rises
//   load_done  out  1  one-cycle pulse: frame accepted
//   load_err   out  1  one-cycle pulse: frame rejected
// -----------------------------------------------------------------------------
module iram_loader #(
    parameter logic [7:0]  SYNC_BYTE      = 8'hA5
`ifdef LOADER_TIMEOUT_EN
    ,
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd2700000
`endif
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic [7:0] ram_wadr,
    output logic [7:0] ram_wdata,
    output logic       ram_wen,
    output logic       cpu_run,
    output logic [7:0] start_pc,
    output logic       load_done,
    output logic       load_err
);

    // Parser states
    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_ADR  = 3'd1;
    localparam logic [2:0] ST_LEN  = 3'd2;
    localparam logic [2:0] ST_DATA = 3'd3;
    localparam logic [2:0] ST_SUM  = 3'd4;

    // Modulo-256 accumulate used for the running checksum
    function automatic logic [7:0] sum8(input logic [7:0] a, input logic [7:0] b);
        return a + b;
    endfunction

    // A frame is good when the running sum plus the trailing SUM byte wraps to zero
    function automatic logic frame_ok(input logic [7:0] acc, input logic [7:0] last);
        return (sum8(acc, last) == 8'd0);
    endfunction

    // State registers
    logic [2:0] state_r;
    logic [7:0] base_r;
    logic [7:0] ptr_r;
    logic [7:0] sum_r;
    logic [7:0] count_r;

    // Next-state values
    logic [2:0] state_s;
    logic [7:0] base_s;
    logic [7:0] ptr_s;
    logic [7:0] sum_s;
    logic [7:0] count_s;
    logic [7:0] wadr_s;
    logic [7:0] wdata_s;
    logic       wen_s;
    logic       run_s;
    logic [7:0] pc_s;
    logic       done_s;
    logic       err_s;

`ifdef LOADER_TIMEOUT_EN
    logic [23:0] timer_r;
    logic [23:0] timer_s;
    logic        timeout_s;

    // Timeout flag: a frame is in progress and no byte has arrived for TIMEOUT_CYCLES clocks
    always_comb begin
        timeout_s = 1'b0;
        if ((state_r != ST_IDLE) && (timer_r >= TIMEOUT_CYCLES)) begin
            timeout_s = 1'b1;
        end else begin
            timeout_s = 1'b0;
        end
    end

    // Inter-byte timer: cleared by every strobe and while idle, otherwise counts up
    always_comb begin
        timer_s = timer_r;
        if (rx_valid) begin
            timer_s = 24'd0;
        end else if (state_r == ST_IDLE) begin
            timer_s = 24'd0;
        end else if (timeout_s) begin
            timer_s = 24'd0;
        end else begin
            timer_s = timer_r + 24'd1;
        end
    end
`endif

    // Frame parser: decides next state, checksum bookkeeping and output values
    always_comb begin
        state_s = state_r;
        base_s  = base_r;
        ptr_s   = ptr_r;
        sum_s   = sum_r;
        count_s = count_r;
        wadr_s  = ram_wadr;
        wdata_s = ram_wdata;
        wen_s   = 1'b0;
        run_s   = cpu_run;
        pc_s    = start_pc;
        done_s  = 1'b0;
        err_s   = 1'b0;

        if (rx_valid) begin
            case (state_r)
                ST_IDLE: begin
                    // Only the marker starts a frame; noise leaves cpu_run alone
                    if (rx_data == SYNC_BYTE) begin
                        state_s = ST_ADR;
                        run_s   = 1'b0;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
                ST_ADR: begin
                    base_s  = rx_data;
                    ptr_s   = rx_data;
                    sum_s   = rx_data;
                    state_s = ST_LEN;
                end
                ST_LEN: begin
                    count_s = rx_data;
                    sum_s   = sum8(sum_r, rx_data);
                    state_s = ST_DATA;
                end
                ST_DATA: begin
                    // Write is presented the cycle after the byte; pointer wraps FF->00
                    wadr_s  = ptr_r;
                    wdata_s = rx_data;
                    wen_s   = 1'b1;
                    ptr_s   = ptr_r + 8'd1;
                    sum_s   = sum8(sum_r, rx_data);
                    if (count_r == 8'd0) begin
                        state_s = ST_SUM;
                    end else begin
                        count_s = count_r - 8'd1;
                        state_s = ST_DATA;
                    end
                end
                ST_SUM: begin
                    state_s = ST_IDLE;
                    if (frame_ok(sum_r, rx_data)) begin
                        done_s = 1'b1;
                        run_s  = 1'b1;
                        pc_s   = base_r;
                    end else begin
                        // Data already written stays in RAM; the CPU remains held
                        err_s  = 1'b1;
                        run_s  = 1'b0;
                    end
                end
                default: begin
                    state_s = ST_IDLE;
                    run_s   = 1'b0;
                end
            endcase
        end else begin
`ifdef LOADER_TIMEOUT_EN
            if (timeout_s) begin
                state_s = ST_IDLE;
                err_s   = 1'b1;
                run_s   = 1'b0;
            end else begin
                state_s = state_r;
            end
`else
            state_s = state_r;
`endif
        end
    end

    // Register update: parser state and all outputs are flopped
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            base_r    <= 8'd0;
            ptr_r     <= 8'd0;
            sum_r     <= 8'd0;
            count_r   <= 8'd0;
            ram_wadr  <= 8'd0;
            ram_wdata <= 8'd0;
            ram_wen   <= 1'b0;
            cpu_run   <= 1'b0;
            start_pc  <= 8'd0;
            load_done <= 1'b0;
            load_err  <= 1'b0;
        end else begin
            state_r   <= state_s;
            base_r    <= base_s;
            ptr_r     <= ptr_s;
            sum_r     <= sum_s;
            count_r   <= count_s;
            ram_wadr  <= wadr_s;
            ram_wdata <= wdata_s;
            ram_wen   <= wen_s;
            cpu_run   <= run_s;
            start_pc  <= pc_s;
            load_done <= done_s;
            load_err  <= err_s;
        end
    end

`ifdef LOADER_TIMEOUT_EN
    // Inter-byte timer register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer_r <= 24'd0;
        end else begin
            timer_r <= timer_s;
        end
    end
`endif

endmodule

// File: tb/tb_iram_loader.sv
// -----------------------------------------------------------------------------
// tb_iram_loader
//
// Scoreboard bench for iram_loader. The stimulus side turns each frame into a
// list of expected events (RAM writes, then accept or reject) using frame-level
// arithmetic and pushes them into a queue; an independent monitor pops and
// compares whenever the DUT pulses ram_wen, load_done or load_err.
// -----------------------------------------------------------------------------
module tb_iram_loader;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] rx_data = 8'd0;
    logic       rx_valid = 1'b0;
    logic [7:0] ram_wadr;
    logic [7:0] ram_wdata;
    logic       ram_wen;
    logic       cpu_run;
    logic [7:0] start_pc;
    logic       load_done;
    logic       load_err;

    iram_loader dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .ram_wadr  (ram_wadr),
        .ram_wdata (ram_wdata),
        .ram_wen   (ram_wen),
        .cpu_run   (cpu_run),
        .start_pc  (start_pc),
        .load_done (load_done),
        .load_err  (load_err)
    );

    always #5 clk = ~clk;

    localparam int EV_WR   = 0;
    localparam int EV_DONE = 1;
    localparam int EV_ERR  = 2;

    typedef struct {
        int         kind;
        logic [7:0] a;
        logic [7:0] d;
    } ev_t;

    typedef logic [7:0] byteq_t[$];

    ev_t        exp_q[$];
    int         n_checks = 0;
    int         n_fail = 0;
    bit         run_exp = 1'b0;
    logic [7:0] pc_exp = 8'd0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Reference model: derive the expected event list from a whole frame
    task automatic expect_frame(input byteq_t f);
        int  adr;
        int  n;
        int  total;
        ev_t e;
        adr   = int'(f[1]);
        n     = int'(f[2]) + 1;
        total = adr + int'(f[2]);
        run_exp = 1'b0;
        for (int i = 0; i < n; i++) begin
            e.kind = EV_WR;
            e.a    = 8'((adr + i) % 256);
            e.d    = f[3 + i];
            exp_q.push_back(e);
            total += int'(f[3 + i]);
        end
        total += int'(f[3 + n]);
        e.a = f[1];
        e.d = 8'd0;
        if ((total % 256) == 0) begin
            e.kind  = EV_DONE;
            run_exp = 1'b1;
            pc_exp  = f[1];
        end else begin
            e.kind  = EV_ERR;
        end
        exp_q.push_back(e);
    endtask

    // Build a random frame of n data bytes with a correct or corrupted checksum
    task automatic make_frame(input logic [7:0] adr, input int n, input bit good, output byteq_t f);
        int total;
        int chk;
        logic [7:0] b;
        f = {};
        f.push_back(8'hA5);
        f.push_back(adr);
        f.push_back(8'(n - 1));
        total = int'(adr) + n - 1;
        for (int i = 0; i < n; i++) begin
            b = 8'($urandom_range(0, 255));
            f.push_back(b);
            total += int'(b);
        end
        chk = (256 - (total % 256)) % 256;
        if (!good) begin
            chk = (chk + $urandom_range(1, 255)) % 256;
        end
        f.push_back(8'(chk));
    endtask

    // Drive bytes as rx_valid strobes, back to back or with random gaps
    task automatic drive(input byteq_t q, input bit gaps);
        int g;
        @(negedge clk);
        foreach (q[i]) begin
            rx_data  = q[i];
            rx_valid = 1'b1;
            @(negedge clk);
            rx_valid = 1'b0;
            g = gaps ? $urandom_range(0, 2) : 0;
            repeat (g) @(negedge clk);
        end
    endtask

    // Wait (bounded) for all expected events, then check the run/PC state
    task automatic drain(input string tag);
        int t;
        t = 0;
        while ((exp_q.size() != 0) && (t < 50)) begin
            @(negedge clk);
            t++;
        end
        check({tag, "_drain_left"}, exp_q.size(), 0);
        exp_q = {};
        repeat (2) @(negedge clk);
        check({tag, "_cpu_run"}, cpu_run, run_exp);
        if (run_exp) begin
            check({tag, "_start_pc"}, start_pc, pc_exp);
        end else begin
            check({tag, "_no_done"}, load_done, 0);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_ram_wadr"}, ram_wadr, 0);
        check({tag, "_ram_wdata"}, ram_wdata, 0);
        check({tag, "_ram_wen"}, ram_wen, 0);
        check({tag, "_cpu_run"}, cpu_run, 0);
        check({tag, "_start_pc"}, start_pc, 0);
        check({tag, "_load_done"}, load_done, 0);
        check({tag, "_load_err"}, load_err, 0);
    endtask

    // Monitor: compare every output event against the scoreboard
    initial begin : monitor
        ev_t e;
        int  k;
        forever begin
            @(posedge clk);
            #1;
            if (rst_n && (ram_wen || load_done || load_err)) begin
                k = ram_wen ? EV_WR : (load_done ? EV_DONE : EV_ERR);
                check("single_event", 32'(ram_wen) + 32'(load_done) + 32'(load_err), 1);
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_event: actual kind=%0d wadr=%0h wdata=%0h required=none",
                             k, ram_wadr, ram_wdata);
                end else begin
                    e = exp_q.pop_front();
                    check("event_kind", k, e.kind);
                    if ((k == EV_WR) && (e.kind == EV_WR)) begin
                        check("wr_addr", ram_wadr, e.a);
                        check("wr_data", ram_wdata, e.d);
                    end else if ((k == EV_DONE) && (e.kind == EV_DONE)) begin
                        check("done_start_pc", start_pc, e.a);
                        check("done_cpu_run", cpu_run, 1);
                    end else if ((k == EV_ERR) && (e.kind == EV_ERR)) begin
                        check("err_cpu_run", cpu_run, 0);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        byteq_t f;
        byteq_t z;
        logic [7:0] b;
        int nn;
        int n;
        bit good;

        // Reset state
        repeat (3) @(negedge clk);
        check_reset_values("reset");
        rst_n = 1'b1;

        // Directed frames
        f = '{8'hA5, 8'h10, 8'h02, 8'h11, 8'h22, 8'h33, 8'h88};
        expect_frame(f); drive(f, 1'b0); drain("good");

        f = '{8'hA5, 8'hFE, 8'h02, 8'h01, 8'h02, 8'h03, 8'hFA};
        expect_frame(f); drive(f, 1'b1); drain("wrap");

        f = '{8'hA5, 8'h10, 8'h00, 8'h44, 8'h00};
        expect_frame(f); drive(f, 1'b0); drain("badsum");

        z = '{8'h00, 8'hFF, 8'h5A};
        drive(z, 1'b0);
        f = '{8'hA5, 8'h20, 8'h00, 8'h77, 8'h69};
        expect_frame(f); drive(f, 1'b0); drain("noise");

        // SYNC value inside a frame is plain data
        f = '{8'hA5, 8'h30, 8'h01, 8'hA5, 8'hA5, 8'h85};
        expect_frame(f); drive(f, 1'b0); drain("sync_data");

        // New marker drops cpu_run on the next cycle
        z = '{8'hA5};
        drive(z, 1'b0);
        check("sync_clears_run", cpu_run, 0);

        // Reset mid-frame after the LEN byte
        z = '{8'h10, 8'h02};
        drive(z, 1'b0);
        rst_n = 1'b0;
        #2;
        check_reset_values("midreset");
        @(negedge clk);
        rst_n   = 1'b1;
        run_exp = 1'b0;
        pc_exp  = 8'd0;
        f = '{8'hA5, 8'h10, 8'h02, 8'h11, 8'h22, 8'h33, 8'h88};
        expect_frame(f); drive(f, 1'b1); drain("after_reset");

        // Randomized frames with noise between them
        for (int k = 0; k < 24; k++) begin
            z  = {};
            nn = $urandom_range(0, 3);
            for (int i = 0; i < nn; i++) begin
                b = 8'($urandom_range(0, 255));
                if (b == 8'hA5) begin
                    b = 8'h00;
                end
                z.push_back(b);
            end
            if (nn != 0) begin
                drive(z, 1'b1);
            end
            n    = (k == 5) ? 256 : $urandom_range(1, 12);
            good = ($urandom_range(0, 3) != 0);
            make_frame(8'($urandom_range(0, 255)), n, good, f);
            expect_frame(f);
            drive(f, (k % 2) == 0);
            drain("rand");
        end

        check("final_queue_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
